// File: rtl/register_file_mp.sv
// Parametrised multi-port register file: flop array, combinational reads,
// optional hardwired zero register, optional same-cycle write-to-read bypass.
module register_file_mp #(
    parameter int  DATA_W   = 32,
    parameter int  NUM_REGS = 32,
    localparam int ADDR_W   = $clog2(NUM_REGS),
    parameter int  NUM_RD   = 2,
    parameter int  NUM_WR   = 1,
    parameter int  ZERO_REG = 1,
    parameter int  BYPASS   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_reg,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_reg,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     wr_conflict
);

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $fatal(1, "register_file_mp: NUM_RD must be 1..4");
    end
    if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
        $fatal(1, "register_file_mp: NUM_WR must be 1..2");
    end
    if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
        $fatal(1, "register_file_mp: NUM_REGS must be a power of two >= 2");
    end

    function automatic logic is_writable(input logic [ADDR_W-1:0] idx);
        return !((ZERO_REG != 0) && (idx == '0));
    endfunction

    logic [DATA_W-1:0] w_regs [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign w_regs[i] = '0;
        end else begin : g_flop
            logic              w_we;
            logic [DATA_W-1:0] w_wd;
            logic [DATA_W-1:0] r_q;

            // NOTE: blocking assignments in always_comb, with every output given a
            // default first so no latch is inferred; the later port overrides the earlier.
            always_comb begin
                w_we = 1'b0;
                w_wd = r_q;
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] && (wr_reg[k*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
                        w_we = 1'b1;
                        w_wd = wr_data[k*DATA_W +: DATA_W];
                    end
                end
            end

            // NOTE: sequential state uses non-blocking assignments only. This is a
            // flop array rather than a memory macro, so every entry can be reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '0;
                end else if (w_we) begin
                    r_q <= w_wd;
                end
            end

            assign w_regs[i] = r_q;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] w_idx;
        logic [DATA_W-1:0] w_val;

        assign w_idx = rd_reg[j*ADDR_W +: ADDR_W];

        // Bypass follows the same port-1-wins priority as the write path.
        always_comb begin
            w_val = w_regs[w_idx];
            if ((BYPASS != 0) && !rst && is_writable(w_idx)) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] && (wr_reg[k*ADDR_W +: ADDR_W] == w_idx)) begin
                        w_val = wr_data[k*DATA_W +: DATA_W];
                    end
                end
            end
        end

        assign rd_data[j*DATA_W +: DATA_W] = w_val;
    end

    if (NUM_WR == 2) begin : g_conflict
        logic r_conflict;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_conflict <= 1'b0;
            end else begin
                r_conflict <= (&wr_en)
                           && (wr_reg[0 +: ADDR_W] == wr_reg[ADDR_W +: ADDR_W])
                           && is_writable(wr_reg[0 +: ADDR_W]);
            end
        end

        assign wr_conflict = r_conflict;
    end else begin : g_no_conflict
        assign wr_conflict = 1'b0;
    end

endmodule
